// File: rtl/alu_result_uart_tx.sv
// Queues 8-bit ALU results and sends each one LSB-first as a UART 8N1 frame.
// Latency: push at cycle N makes tx go low (start bit) at N+2 if idle; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: result_ready drops while the FIFO is full; a push while full is dropped and sets sticky overflow.
module alu_result_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    result_in,
    input  logic                          result_valid,
    output logic                          result_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          bit_done;

    // Full is judged on the start-of-cycle count, so a pop in the same cycle never rescues a push.
    assign full         = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign push         = result_valid && !full;
    assign bit_done     = (timer == BIT_LAST);
    assign pop          = (fifo_count != '0) && ((state == IDLE) || (state == STOP && bit_done));
    assign result_ready = !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (result_valid && full) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // tx/busy are loaded with the value belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else if (pop) begin
            shift_reg <= mem[rd_ptr];
            state     <= START;
            timer     <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= shift_reg[0];
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state <= IDLE;
                        timer <= '0;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// tx/busy are logged once per cycle so frames can be checked cycle-by-cycle and decoded.
module tb_alu_result_uart_tx;

    localparam int CPB  = 4;
    localparam int DEP  = 4;
    localparam int LOGN = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] result_in = 8'h00;
    logic       result_valid = 1'b0;
    logic       result_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic       txlog   [LOGN];
    logic       busylog [LOGN];
    int         lc     = 0;
    bit         log_on = 1'b0;
    logic [7:0] rx_q [$];

    alu_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_in    (result_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .tx           (tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Index of each log entry equals the cycle number since the test's cycle 0.
    always @(negedge clk) begin
        if (log_on && lc < LOGN) begin
            txlog[lc]   = tx;
            busylog[lc] = busy;
            lc++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int k);
        while (lc < k) next_cycle();
    endtask

    task automatic do_reset();
        log_on       = 1'b0;
        result_valid = 1'b0;
        rst          = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic start_test();
        @(posedge clk);
        #1;
        lc     = 0;
        log_on = 1'b1;
    endtask

    task automatic push_now(input logic [7:0] d);
        result_in    = d;
        result_valid = 1'b1;
        next_cycle();
        result_valid = 1'b0;
    endtask

    // Independent UART receiver: samples each bit in the middle of its period.
    task automatic decode(input int n);
        int i;
        logic [7:0] b;
        rx_q.delete();
        i = 0;
        while (i + 10*CPB - 1 < n) begin
            if (txlog[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = txlog[i + CPB*(k+1) + CPB/2];
                check($sformatf("stop_bit_%0d", rx_q.size()), txlog[i + 9*CPB + CPB/2], 1);
                rx_q.push_back(b);
                i += 10*CPB;
            end else begin
                i++;
            end
        end
    endtask

    logic [7:0] pat;
    int         cnt;

    initial begin
        // Reset state
        do_reset();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ready", result_ready, 1);

        // Single frame 0xA5
        start_test();
        push_now(8'hA5);
        check("sf_count_c1", fifo_count, 1);
        goto_cycle(43);
        check("sf_tx_c1", txlog[1], 1);
        check("sf_busy_c1", busylog[1], 0);
        pat = 8'hA5;
        for (int c = 2; c < 42; c++) begin
            if (c < 6)       check($sformatf("sf_tx_c%0d", c), txlog[c], 0);
            else if (c < 38) check($sformatf("sf_tx_c%0d", c), txlog[c], pat[(c-6)/CPB]);
            else             check($sformatf("sf_tx_c%0d", c), txlog[c], 1);
            check($sformatf("sf_busy_c%0d", c), busylog[c], 1);
        end
        check("sf_busy_c42", busylog[42], 0);
        check("sf_tx_c42", txlog[42], 1);
        check("sf_count_end", fifo_count, 0);

        // Back-to-back 0x01, 0x02
        do_reset();
        start_test();
        push_now(8'h01);
        push_now(8'h02);
        check("bb_count_c2", fifo_count, 1);
        goto_cycle(100);
        cnt = 0;
        for (int c = 0; c < 100; c++) cnt += busylog[c];
        check("bb_busy_cycles", cnt, 80);
        check("bb_busy_c81", busylog[81], 1);
        check("bb_busy_c82", busylog[82], 0);
        check("bb_stop_c41", txlog[41], 1);
        check("bb_start_c42", txlog[42], 0);
        decode(100);
        check("bb_nframes", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("bb_byte0", rx_q[0], 8'h01);
            check("bb_byte1", rx_q[1], 8'h02);
        end
        check("bb_count_end", fifo_count, 0);

        // Overflow: 0x10..0x15 on consecutive cycles
        do_reset();
        start_test();
        check("ov_ovf_c0", overflow, 0);
        for (int i = 0; i < 6; i++) begin
            result_in    = 8'(8'h10 + i);
            result_valid = 1'b1;
            next_cycle();
        end
        result_valid = 1'b0;
        check("ov_ovf_c6", overflow, 1);
        check("ov_ready_c6", result_ready, 0);
        check("ov_count_c6", fifo_count, 4);
        goto_cycle(215);
        decode(215);
        check("ov_nframes", rx_q.size(), 5);
        if (rx_q.size() == 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("ov_byte%0d", i), rx_q[i], 8'h10 + i);
        end
        check("ov_sticky", overflow, 1);
        check("ov_ready_end", result_ready, 1);

        // Push coincident with pop in the last STOP cycle
        do_reset();
        start_test();
        push_now(8'h40);
        push_now(8'h41);
        goto_cycle(40);
        check("pp_count_c40", fifo_count, 1);
        goto_cycle(41);
        push_now(8'h33);
        check("pp_count_c42", fifo_count, 1);
        check("pp_tx_c42", tx, 0);
        check("pp_busy_c42", busy, 1);
        goto_cycle(130);
        decode(130);
        check("pp_nframes", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("pp_byte0", rx_q[0], 8'h40);
            check("pp_byte1", rx_q[1], 8'h41);
            check("pp_byte2", rx_q[2], 8'h33);
        end
        check("pp_count_end", fifo_count, 0);

        // Reset during data bit 3 of 0x0F with two bytes queued
        do_reset();
        start_test();
        push_now(8'h0F);
        push_now(8'hAA);
        push_now(8'hBB);
        goto_cycle(19);
        check("rm_count_c19", fifo_count, 2);
        check("rm_tx_c19", tx, 1);
        check("rm_busy_c19", busy, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("rm_tx", tx, 1);
        check("rm_busy", busy, 0);
        check("rm_count", fifo_count, 0);
        check("rm_ovf", overflow, 0);
        goto_cycle(61);
        cnt = 0;
        for (int c = 20; c < 61; c++) cnt += (txlog[c] == 1'b0) ? 1 : 0;
        check("rm_tx_low_after", cnt, 0);
        cnt = 0;
        for (int c = 20; c < 61; c++) cnt += busylog[c];
        check("rm_busy_after", cnt, 0);

        // Data extremes 0x00 then 0xFF
        do_reset();
        start_test();
        push_now(8'h00);
        push_now(8'hFF);
        goto_cycle(90);
        cnt = 0;
        for (int c = 2; c < 42; c++) cnt += (txlog[c] == 1'b0) ? 1 : 0;
        check("x00_low_cycles", cnt, 9*CPB);
        check("x00_stop_c38", txlog[38], 1);
        cnt = 0;
        for (int c = 42; c < 82; c++) cnt += (txlog[c] == 1'b0) ? 1 : 0;
        check("xff_low_cycles", cnt, CPB);
        check("xff_start_c45", txlog[45], 0);
        check("xff_data_c46", txlog[46], 1);
        decode(90);
        check("x_nframes", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("x_byte0", rx_q[0], 8'h00);
            check("x_byte1", rx_q[1], 8'hFF);
        end

        log_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
